tick_paced_writer: RTL and testbench

- Consumes the divided slow-clock level produced in the `clk` domain and turns each rising edge of it into a single-cycle FIFO write strobe.
- Generates a burst of test data and pushes it into the FIFO write port at the slow rate.
- Respects back-pressure from the FIFO full flag and counts any slow ticks it has to drop.
- Serves as the paced stimulus source that sits between the clock divider and the FIFO under test.

---
 rtl/tick_paced_writer.sv | 109 ++++++++++
 tb/tb_tick_paced_writer.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/tick_paced_writer.sv
// Paced FIFO stimulus source: each rising edge of a divided clock level becomes
// one write strobe carrying a binary or Gray-coded count, with full-flag back-pressure.
module tick_paced_writer #(
  parameter int                 DATA_W    = 8,
  parameter int                 BURST_LEN = 16,
  parameter logic [DATA_W-1:0]  START_VAL = '0,
  parameter int                 DROP_W    = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              slow_clk_in,
  input  logic              start,
  input  logic              stop,
  input  logic              mode,
  input  logic              fifo_full,
  output logic              wr_en,
  output logic [DATA_W-1:0] wr_data,
  output logic              busy,
  output logic              done,
  output logic [DROP_W-1:0] drop_cnt
);

  localparam int SENT_W = $clog2(BURST_LEN + 1);
  localparam logic [SENT_W-1:0] LAST_SENT = SENT_W'(BURST_LEN - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t              state;
  logic                slow_prev;
  logic                mode_q;
  logic [DATA_W-1:0]   counter;
  logic [SENT_W-1:0]   sent;
  logic                tick;

  function automatic logic [DATA_W-1:0] to_gray(input logic [DATA_W-1:0] v);
    return v ^ (v >> 1);
  endfunction

  function automatic logic [DROP_W-1:0] sat_inc(input logic [DROP_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  assign tick = slow_clk_in & ~slow_prev;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      slow_prev <= 1'b1;
      mode_q    <= 1'b0;
      counter   <= START_VAL;
      sent      <= '0;
      wr_en     <= 1'b0;
      wr_data   <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      drop_cnt  <= '0;
    end else begin
      slow_prev <= slow_clk_in;
      wr_en     <= 1'b0;
      done      <= 1'b0;
      case (state)
        IDLE: begin
          // stop dominates a simultaneous start
          if (start && !stop) begin
            state    <= RUN;
            busy     <= 1'b1;
            counter  <= START_VAL;
            sent     <= '0;
            drop_cnt <= '0;
            mode_q   <= mode;
          end
        end
        RUN: begin
          if (stop) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else if (tick) begin
            if (!fifo_full) begin
              wr_en   <= 1'b1;
              wr_data <= mode_q ? to_gray(counter) : counter;
              counter <= counter + 1'b1;
              sent    <= sent + 1'b1;
              if (sent == LAST_SENT) begin
                state <= DONE;
                busy  <= 1'b0;
              end
            end else begin
              // counter and sent hold so the same value is retried next tick
              drop_cnt <= sat_inc(drop_cnt);
            end
          end
        end
        DONE: begin
          state <= IDLE;
          done  <= 1'b1;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_tick_paced_writer.sv
// Directed bench for tick_paced_writer: burst vector table plus hand-written
// sequences for stop, reset and start/stop corner cases.
module tb_tick_paced_writer;

  localparam int DATA_W    = 8;
  localparam int BURST_LEN = 4;
  localparam int DROP_W    = 16;

  logic              clk = 1'b0;
  logic              rst_n, slow_clk_in, start, stop, mode, fifo_full;
  logic              wr_en, busy, done;
  logic [DATA_W-1:0] wr_data;
  logic [DROP_W-1:0] drop_cnt;

  tick_paced_writer #(
    .DATA_W(DATA_W), .BURST_LEN(BURST_LEN), .START_VAL(8'hFE), .DROP_W(DROP_W)
  ) dut (
    .clk(clk), .rst_n(rst_n), .slow_clk_in(slow_clk_in), .start(start),
    .stop(stop), .mode(mode), .fifo_full(fifo_full), .wr_en(wr_en),
    .wr_data(wr_data), .busy(busy), .done(done), .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        mode;
    logic        toggle;
    logic [3:0]  full_tick;
    logic [31:0] data;
    logic [7:0]  drop;
    logic [7:0]  ticks;
  } vec_t;

  vec_t vecs[4];
  int   total = 0, fails = 0;
  int   ph = 0, cyc = 0, tick_no = 0, full_tick = 0;
  bit   slow_run = 1'b0, toggle = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Advance one clk and sample just after the edge; the slow clock rises every 4 clk.
  task automatic step();
    logic old;
    @(posedge clk);
    #1;
    cyc++;
    ph = (ph + 1) % 4;
    old = slow_clk_in;
    if (slow_run) slow_clk_in = (ph >= 2);
    fifo_full = 1'b0;
    if (slow_run && slow_clk_in && !old) begin
      tick_no++;
      fifo_full = (tick_no == full_tick);
    end
    if (toggle) mode = ~mode;
  endtask

  task automatic wait_writes(input int n, output logic [7:0] last);
    int got = 0;
    last = '0;
    for (int i = 0; i < 200 && got < n; i++) begin
      step();
      if (wr_en) begin
        got++;
        last = wr_data;
      end
    end
    chk("write_count", got, n);
  endtask

  task automatic wait_done();
    for (int i = 0; i < 200; i++) begin
      step();
      if (done) break;
    end
    chk("done_seen", done, 1);
  endtask

  task automatic run_vec(input vec_t v);
    int nwr = 0, last_cyc = 0, done_cyc = -100, ticks_at_last = 0;
    logic [7:0] got [4];
    for (int k = 0; k < 4; k++) got[k] = '0;
    mode = v.mode;
    full_tick = int'(v.full_tick);
    tick_no = 0;
    start = 1'b1;
    step();
    start = 1'b0;
    toggle = v.toggle;
    chk("busy_after_start", busy, 1);
    for (int i = 0; i < 200; i++) begin
      step();
      if (wr_en) begin
        if (nwr < 4) got[nwr] = wr_data;
        if (nwr > 0 && v.full_tick == 0) chk("write_spacing", cyc - last_cyc, 4);
        nwr++;
        last_cyc = cyc;
        ticks_at_last = tick_no;
      end
      if (done) begin
        done_cyc = cyc;
        break;
      end
    end
    toggle = 1'b0;
    full_tick = 0;
    chk("burst_writes", nwr, 4);
    for (int k = 0; k < 4; k++) chk("burst_data", got[k], v.data[31-8*k -: 8]);
    chk("done_after_last_write", done_cyc - last_cyc, 1);
    chk("busy_at_done", busy, 0);
    chk("drop_at_done", drop_cnt, v.drop);
    chk("ticks_consumed", ticks_at_last, v.ticks);
    step();
    chk("done_one_cycle", done, 0);
    chk("busy_after_done", busy, 0);
  endtask

  initial begin
    logic [7:0] last;
    int seen;
    vecs[0] = '{1'b0, 1'b0, 4'd0, 32'hFEFF0001, 8'd0, 8'd4};
    vecs[1] = '{1'b1, 1'b1, 4'd0, 32'h81800001, 8'd0, 8'd4};
    vecs[2] = '{1'b0, 1'b0, 4'd2, 32'hFEFF0001, 8'd1, 8'd5};
    vecs[3] = '{1'b1, 1'b0, 4'd3, 32'h81800001, 8'd1, 8'd5};

    rst_n = 1'b0; slow_clk_in = 1'b1; start = 1'b0; stop = 1'b0;
    mode = 1'b0; fifo_full = 1'b0;
    step();
    step();
    chk("reset_outputs", {wr_en, busy, done, wr_data, drop_cnt}, '0);

    // Release reset with the slow level already high: no tick until a real rise.
    rst_n = 1'b1;
    start = 1'b1;
    step();
    start = 1'b0;
    chk("busy_after_reset_start", busy, 1);
    seen = 0;
    repeat (5) begin
      step();
      if (wr_en) seen++;
    end
    chk("no_write_held_high", seen, 0);
    slow_clk_in = 1'b0;
    step();
    chk("no_write_on_fall", wr_en, 0);
    slow_clk_in = 1'b1;
    step();
    chk("write_latency_1clk", wr_en, 1);
    chk("first_data", wr_data, 8'hFE);
    stop = 1'b1;
    step();
    stop = 1'b0;
    chk("stop_clears_busy", busy, 0);
    ph = 3;
    slow_run = 1'b1;
    step();
    step();

    for (int i = 0; i < 4; i++) run_vec(vecs[i]);

    // Stop after the 2nd write, with the 1st tick dropped by a full FIFO.
    mode = 1'b0;
    tick_no = 0;
    full_tick = 1;
    start = 1'b1;
    step();
    start = 1'b0;
    wait_writes(2, last);
    chk("stop_seq_last_data", last, 8'hFF);
    full_tick = 0;
    stop = 1'b1;
    step();
    stop = 1'b0;
    chk("stop_busy", busy, 0);
    chk("stop_wr_en", wr_en, 0);
    seen = 0;
    repeat (20) begin
      step();
      if (wr_en || done) seen++;
    end
    chk("stop_no_activity", seen, 0);
    chk("stop_drop_held", drop_cnt, 1);

    // Restart clears drop_cnt; start stays high through DONE to chain a burst.
    start = 1'b1;
    step();
    chk("restart_drop_cleared", drop_cnt, 0);
    chk("restart_busy", busy, 1);
    wait_writes(1, last);
    chk("restart_first_data", last, 8'hFE);
    wait_done();
    chk("chain_busy_at_done", busy, 0);
    step();
    chk("chain_busy_next", busy, 1);
    start = 1'b0;
    stop = 1'b1;
    step();
    stop = 1'b0;
    chk("chain_stopped", busy, 0);

    // Simultaneous start and stop in IDLE.
    start = 1'b1;
    stop = 1'b1;
    step();
    start = 1'b0;
    stop = 1'b0;
    chk("collision_idle", busy, 0);
    step();
    chk("collision_idle_hold", busy, 0);

    // Reset mid-burst aborts silently.
    start = 1'b1;
    step();
    start = 1'b0;
    wait_writes(2, last);
    step();
    rst_n = 1'b0;
    step();
    chk("midburst_reset", {wr_en, busy, done, wr_data, drop_cnt}, '0);
    rst_n = 1'b1;
    seen = 0;
    repeat (12) begin
      step();
      if (wr_en || done || busy) seen++;
    end
    chk("after_reset_silent", seen, 0);

    $display("%0d/%0d checks passed", total - fails, total);
    $finish;
  end

endmodule
